// File: rtl/power_spectrum_avg.sv
// Welch-style power spectrum averager: |X|^2 per bin summed over 2^avg_k frames, then drained with valid/ready.
// Optional peak tracker enabled by defining PSD_PEAK_EN (adds peak_val / peak_index outputs).
module power_spectrum_avg #(
  parameter int DATA_W       = 16,
  parameter int NFFT         = 512,
  parameter int Q            = 15,
  parameter int LOG2_AVG_MAX = 4,
  parameter int ACC_W        = 2*DATA_W+1+LOG2_AVG_MAX,
  parameter int OUT_W        = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [DATA_W-1:0]          bin_re,
  input  logic signed [DATA_W-1:0]          bin_im,
  input  logic                              bin_valid,
  input  logic                              bin_last,
  output logic                              bin_ready,
  input  logic [$clog2(LOG2_AVG_MAX+1)-1:0] avg_log2,
  output logic [OUT_W-1:0]                  psd_out,
  output logic [$clog2(NFFT)-1:0]           psd_index,
  output logic                              psd_valid,
  output logic                              psd_last,
  input  logic                              psd_ready,
  output logic                              frame_err
`ifdef PSD_PEAK_EN
  ,
  output logic [OUT_W-1:0]                  peak_val,
  output logic [$clog2(NFFT)-1:0]           peak_index
`endif
);
  localparam int IDX_W = $clog2(NFFT);
  localparam int K_W   = $clog2(LOG2_AVG_MAX+1);
  localparam int P_W   = 2*DATA_W+1;
  localparam int FC_W  = (LOG2_AVG_MAX < 1) ? 1 : LOG2_AVG_MAX;
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({OUT_W{1'b1}});

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  bin_index_q, bin_index_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [K_W-1:0]    avg_k_q, avg_k_d;
  logic              s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
  logic [IDX_W-1:0]  s1_idx_q, s1_idx_d;
  logic [P_W-1:0]    p_q, p_d;
  logic [IDX_W-1:0]  drain_ptr_q, drain_ptr_d, rd_idx_q, rd_idx_d;
  logic              rd_done_q, rd_done_d, rdv_q, rdv_d;
  logic [OUT_W-1:0]  psd_out_q, psd_out_d;
  logic [IDX_W-1:0]  psd_index_q, psd_index_d;
  logic              psd_valid_q, psd_valid_d, psd_last_q, psd_last_d;
  logic              frame_err_q, frame_err_d;

  logic [ACC_W-1:0]  acc_mem [NFFT];
  logic [ACC_W-1:0]  rd_data_q;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_addr;

  logic signed [2*DATA_W-1:0] re_sq, im_sq;
  logic [ACC_W-1:0]  shifted;
  logic [OUT_W-1:0]  psd_sat;
  logic [K_W-1:0]    k_in;
  logic [FC_W:0]     set_len_m1;
  logic              accept, at_end, set_done, out_free, xfer, issue, load;

  always_comb begin
    re_sq      = bin_re * bin_re;
    im_sq      = bin_im * bin_im;
    shifted    = rd_data_q >> (Q + 32'(avg_k_q));
    psd_sat    = (shifted > SAT_MAX) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    k_in       = (avg_log2 > K_W'(LOG2_AVG_MAX)) ? K_W'(LOG2_AVG_MAX) : avg_log2;
    set_len_m1 = (FC_W+1)'((1 << avg_k_q) - 1);
    set_done   = ({1'b0, frame_cnt_q} == set_len_m1);
    at_end     = (bin_index_q == IDX_W'(NFFT-1));
    accept     = bin_valid && (state_q == ACCUM);
    out_free   = !psd_valid_q || psd_ready;
    xfer       = psd_valid_q && psd_ready;
    // Drain reads wait for the final stage-2 write so the last bin is read back fresh.
    issue      = (state_q == DRAIN) && !s1_valid_q && !rd_done_q && (!rdv_q || out_free);
    load       = rdv_q && out_free;

    state_d     = state_q;
    bin_index_d = bin_index_q;
    frame_cnt_d = frame_cnt_q;
    avg_k_d     = avg_k_q;
    s1_valid_d  = 1'b0;
    s1_first_d  = s1_first_q;
    s1_idx_d    = s1_idx_q;
    p_d         = {1'b0, re_sq} + {1'b0, im_sq};
    drain_ptr_d = drain_ptr_q;
    rd_idx_d    = rd_idx_q;
    rd_done_d   = rd_done_q;
    rdv_d       = rdv_q;
    psd_out_d   = psd_out_q;
    psd_index_d = psd_index_q;
    psd_valid_d = psd_valid_q;
    psd_last_d  = psd_last_q;
    frame_err_d = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = bin_index_q;

    if (accept) begin
      rd_en = 1'b1;
      if (bin_last != at_end) begin
        frame_err_d = 1'b1;
        bin_index_d = '0;
        frame_cnt_d = '0;
      end else begin
        s1_valid_d = 1'b1;
        s1_idx_d   = bin_index_q;
        s1_first_d = (frame_cnt_q == '0);
        if (frame_cnt_q == '0 && bin_index_q == '0) avg_k_d = k_in;
        if (at_end) begin
          bin_index_d = '0;
          if (set_done) begin
            frame_cnt_d = '0;
            state_d     = DRAIN;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end else begin
          bin_index_d = bin_index_q + 1'b1;
        end
      end
    end

    if (issue) begin
      rd_en       = 1'b1;
      rd_addr     = drain_ptr_q;
      rd_idx_d    = drain_ptr_q;
      drain_ptr_d = drain_ptr_q + 1'b1;
      if (drain_ptr_q == IDX_W'(NFFT-1)) rd_done_d = 1'b1;
    end
    rdv_d = issue ? 1'b1 : (load ? 1'b0 : rdv_q);

    if (load) begin
      psd_valid_d = 1'b1;
      psd_out_d   = psd_sat;
      psd_index_d = rd_idx_q;
      psd_last_d  = (rd_idx_q == IDX_W'(NFFT-1));
    end else if (xfer) begin
      psd_valid_d = 1'b0;
    end

    if (xfer && psd_last_q) begin
      state_d     = ACCUM;
      frame_cnt_d = '0;
      bin_index_d = '0;
      drain_ptr_d = '0;
      rd_done_d   = 1'b0;
    end
  end

  // Accumulator RAM: read in stage 1 (or drain prefetch), written in stage 2.
  always_ff @(posedge clk) begin
    if (s1_valid_q)
      acc_mem[s1_idx_q] <= s1_first_q ? ACC_W'(p_q) : rd_data_q + ACC_W'(p_q);
    if (rd_en)
      rd_data_q <= acc_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      bin_index_q <= '0;
      frame_cnt_q <= '0;
      avg_k_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_idx_q    <= '0;
      p_q         <= '0;
      drain_ptr_q <= '0;
      rd_idx_q    <= '0;
      rd_done_q   <= 1'b0;
      rdv_q       <= 1'b0;
      psd_out_q   <= '0;
      psd_index_q <= '0;
      psd_valid_q <= 1'b0;
      psd_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_index_q <= bin_index_d;
      frame_cnt_q <= frame_cnt_d;
      avg_k_q     <= avg_k_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_idx_q    <= s1_idx_d;
      p_q         <= p_d;
      drain_ptr_q <= drain_ptr_d;
      rd_idx_q    <= rd_idx_d;
      rd_done_q   <= rd_done_d;
      rdv_q       <= rdv_d;
      psd_out_q   <= psd_out_d;
      psd_index_q <= psd_index_d;
      psd_valid_q <= psd_valid_d;
      psd_last_q  <= psd_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bin_ready = (state_q == ACCUM);
  assign psd_out   = psd_out_q;
  assign psd_index = psd_index_q;
  assign psd_valid = psd_valid_q;
  assign psd_last  = psd_last_q;
  assign frame_err = frame_err_q;

`ifdef PSD_PEAK_EN
  logic [OUT_W-1:0] run_max_q, run_max_d, peak_val_q, peak_val_d, cand_val;
  logic [IDX_W-1:0] run_idx_q, run_idx_d, peak_index_q, peak_index_d, cand_idx;

  always_comb begin
    run_max_d    = run_max_q;
    run_idx_d    = run_idx_q;
    peak_val_d   = peak_val_q;
    peak_index_d = peak_index_q;
    // Strict compare keeps the lowest index on ties; bin 0 restarts the search.
    if (psd_index_q == '0 || psd_out_q > run_max_q) begin
      cand_val = psd_out_q;
      cand_idx = psd_index_q;
    end else begin
      cand_val = run_max_q;
      cand_idx = run_idx_q;
    end
    if (xfer) begin
      run_max_d = cand_val;
      run_idx_d = cand_idx;
      if (psd_last_q) begin
        peak_val_d   = cand_val;
        peak_index_d = cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_max_q    <= '0;
      run_idx_q    <= '0;
      peak_val_q   <= '0;
      peak_index_q <= '0;
    end else begin
      run_max_q    <= run_max_d;
      run_idx_q    <= run_idx_d;
      peak_val_q   <= peak_val_d;
      peak_index_q <= peak_index_d;
    end
  end

  assign peak_val   = peak_val_q;
  assign peak_index = peak_index_q;
`endif
endmodule

// File: tb/tb_power_spectrum_avg.sv
// Directed bench for power_spectrum_avg (NFFT=8): a 32-bit output instance and a 16-bit
// saturating instance share all stimulus; peak outputs are checked when PSD_PEAK_EN is defined.
module tb_power_spectrum_avg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] bin_re = '0, bin_im = '0;
  logic bin_valid = 1'b0, bin_last = 1'b0;
  logic [2:0] avg_log2 = '0;
  logic psd_ready = 1'b1;

  logic        bin_ready, psd_valid, psd_last, frame_err;
  logic [31:0] psd_out;
  logic [2:0]  psd_index;
  logic        s_bin_ready, s_psd_valid, s_psd_last, s_frame_err;
  logic [15:0] s_psd_out;
  logic [2:0]  s_psd_index;
`ifdef PSD_PEAK_EN
  logic [31:0] peak_val;
  logic [2:0]  peak_index;
  logic [15:0] s_peak_val;
  logic [2:0]  s_peak_index;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  power_spectrum_avg #(.DATA_W(16), .NFFT(8), .Q(15), .LOG2_AVG_MAX(4), .OUT_W(32)) dut (
    .clk(clk), .rst(rst), .bin_re(bin_re), .bin_im(bin_im), .bin_valid(bin_valid),
    .bin_last(bin_last), .bin_ready(bin_ready), .avg_log2(avg_log2), .psd_out(psd_out),
    .psd_index(psd_index), .psd_valid(psd_valid), .psd_last(psd_last), .psd_ready(psd_ready),
    .frame_err(frame_err)
`ifdef PSD_PEAK_EN
    , .peak_val(peak_val), .peak_index(peak_index)
`endif
  );

  power_spectrum_avg #(.DATA_W(16), .NFFT(8), .Q(15), .LOG2_AVG_MAX(4), .OUT_W(16)) dut_s (
    .clk(clk), .rst(rst), .bin_re(bin_re), .bin_im(bin_im), .bin_valid(bin_valid),
    .bin_last(bin_last), .bin_ready(s_bin_ready), .avg_log2(avg_log2), .psd_out(s_psd_out),
    .psd_index(s_psd_index), .psd_valid(s_psd_valid), .psd_last(s_psd_last), .psd_ready(psd_ready),
    .frame_err(s_frame_err)
`ifdef PSD_PEAK_EN
    , .peak_val(s_peak_val), .peak_index(s_peak_index)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one frame on negedges; err_at >= 0 raises bin_last early at that index and stops.
  task automatic send_frame(input logic signed [15:0] re0, input logic signed [15:0] re_rest,
                            input logic signed [15:0] im_all, input int err_at);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) check("frame_err_clean", frame_err, 1'b0);
      bin_re    = (i == 0) ? re0 : re_rest;
      bin_im    = im_all;
      bin_valid = 1'b1;
      bin_last  = (err_at >= 0) ? (i == err_at) : (i == 7);
      if (err_at >= 0 && i == err_at) break;
    end
    @(negedge clk);
    bin_valid = 1'b0;
    bin_last  = 1'b0;
    check("frame_err_end", frame_err, (err_at >= 0));
    if (err_at >= 0) begin
      @(negedge clk);
      check("frame_err_pulse_width", frame_err, 1'b0);
    end
  endtask

  task automatic expect_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check("idle_psd_valid", psd_valid, 1'b0);
      check("idle_bin_ready", bin_ready, 1'b1);
      @(negedge clk);
    end
  endtask

  // Collects up to stop_after outputs; mode 1 toggles psd_ready 1,0,0,1.
  task automatic drain(input int exp0, input int exp_rest, input int mode, input int stop_after);
    int n = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [31:0] h_out;
    logic [2:0]  h_idx;
    logic        h_last;
    int e;
    while (n < stop_after && cyc < 200) begin
      psd_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (held) begin
        check("stall_valid", psd_valid, 1'b1);
        check("stall_out", psd_out, h_out);
        check("stall_index", psd_index, h_idx);
        check("stall_last", psd_last, h_last);
      end
      held = 1'b0;
      if (psd_valid && psd_ready) begin
        e = (n == 0) ? exp0 : exp_rest;
        $display("xfer %0d: psd_out=%0d psd_index=%0d psd_last=%0d sat_out=%0d", n, psd_out, psd_index, psd_last, s_psd_out);
        check("psd_out", psd_out, e);
        check("psd_index", psd_index, n);
        check("psd_last", psd_last, (n == 7));
        check("sat_psd_out", s_psd_out, (e > 65535) ? 65535 : e);
        n++;
      end else if (psd_valid) begin
        held   = 1'b1;
        h_out  = psd_out;
        h_idx  = psd_index;
        h_last = psd_last;
      end
      cyc++;
      @(negedge clk);
    end
    psd_ready = 1'b1;
    check("drain_count", n, stop_after);
    if (stop_after == 8) begin
      check("after_drain_valid", psd_valid, 1'b0);
      check("after_drain_ready", bin_ready, 1'b1);
`ifdef PSD_PEAK_EN
      check("peak_val", peak_val, (exp0 >= exp_rest) ? exp0 : exp_rest);
      check("peak_index", peak_index, (exp0 >= exp_rest) ? 0 : 1);
      e = (exp0 >= exp_rest) ? exp0 : exp_rest;
      check("sat_peak_val", s_peak_val, (e > 65535) ? 65535 : e);
      check("sat_peak_index", s_peak_index, (exp0 >= exp_rest) ? 0 : 1);
`endif
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_psd_valid", psd_valid, 1'b0);
    check("rst_psd_out", psd_out, 0);
    check("rst_psd_index", psd_index, 0);
    check("rst_psd_last", psd_last, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_bin_ready", bin_ready, 1'b1);

    // Single frame, 16384^2 >> 15 = 8192; first output 3 cycles after last accept.
    avg_log2 = 3'd0;
    send_frame(16384, 16384, 0, -1);
    check("lat_c0", psd_valid, 1'b0);
    @(negedge clk); check("lat_c1", psd_valid, 1'b0);
    @(negedge clk); check("lat_c2", psd_valid, 1'b0);
    @(negedge clk); check("lat_c3", psd_valid, 1'b1);
    drain(8192, 8192, 0, 8);
    expect_idle(2);

    // Four-frame average: bin0 sum 2^29 >> 17 = 4096.
    avg_log2 = 3'd2;
    send_frame(16384, 0, 0, -1); expect_idle(4);
    send_frame(0, 0, 0, -1);     expect_idle(4);
    send_frame(16384, 0, 0, -1); expect_idle(4);
    send_frame(0, 0, 0, -1);
    drain(4096, 0, 0, 8);
    expect_idle(2);

    // Backpressure with the single-frame stimulus.
    avg_log2 = 3'd0;
    send_frame(16384, 16384, 0, -1);
    drain(8192, 8192, 1, 8);
    expect_idle(2);

    // Frame-length error, then two clean frames: (2^28 + 2^26) >> 16 = 5120.
    avg_log2 = 3'd1;
    send_frame(16384, 16384, 0, 5);
    expect_idle(4);
    send_frame(16384, 16384, 0, -1);
    expect_idle(4);
    send_frame(8192, 8192, 0, -1);
    drain(5120, 5120, 0, 8);
    expect_idle(2);

    // Saturation: 2^31 >> 15 = 65536, clamps to 65535 on the 16-bit instance.
    avg_log2 = 3'd0;
    send_frame(-32768, -32768, -32768, -1);
    drain(65536, 65536, 0, 8);
    expect_idle(2);

    // Reset after the third output, then a fresh frame: 8192^2 >> 15 = 2048.
    send_frame(16384, 16384, 0, -1);
    drain(8192, 8192, 0, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_psd_valid", psd_valid, 1'b0);
    check("midrst_bin_ready", bin_ready, 1'b1);
    check("midrst_psd_out", psd_out, 0);
    send_frame(8192, 8192, 0, -1);
    drain(2048, 2048, 0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
